// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between icache0/dcache0/icache1/dcache1
// and holds one LL reservation per core for SC success/failure.
// Ports:
//   CLK, nRST          clock, async active-low reset
//   iREN/iaddr         per-core instruction read requests (core n in slice n)
//   ihit/iload         one-cycle instruction completion pulse and data
//   dREN/dWEN/datomic  per-core data requests; datomic makes LL / SC
//   daddr/dstore       per-core data address and write data
//   dhit/dload         one-cycle data completion pulse, read data / SC result
//   ramREN/ramWEN      RAM enables, driven only while a grant is BUSY
//   ramaddr/ramstore   RAM address and write data
//   ramload/ramstate   RAM read data and status (FREE/BUSY/ACCESS/ERROR)
module mem_arbiter #(
  parameter int WORD_W  = 32,
  parameter bit RR_INIT = 1'b0
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic [1:0]          iREN,
  input  logic [2*WORD_W-1:0] iaddr,
  output logic [1:0]          ihit,
  output logic [2*WORD_W-1:0] iload,
  input  logic [1:0]          dREN,
  input  logic [1:0]          dWEN,
  input  logic [1:0]          datomic,
  input  logic [2*WORD_W-1:0] daddr,
  input  logic [2*WORD_W-1:0] dstore,
  output logic [1:0]          dhit,
  output logic [2*WORD_W-1:0] dload,
  output logic                ramREN,
  output logic                ramWEN,
  output logic [WORD_W-1:0]   ramaddr,
  output logic [WORD_W-1:0]   ramstore,
  input  logic [WORD_W-1:0]   ramload,
  input  logic [1:0]          ramstate
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    SCFAIL,
    GAP
  } state_t;

  localparam logic [1:0] RS_ACCESS = 2'd2;

  state_t                   r_state;
  logic                     r_last;
  logic                     r_gnt_c;
  logic                     r_gnt_d;
  logic [1:0]               r_link_v;
  logic [1:0][WORD_W-1:0]   r_link_a;

  logic [1:0][WORD_W-1:0]   w_iaddr;
  logic [1:0][WORD_W-1:0]   w_daddr;
  logic [1:0][WORD_W-1:0]   w_dstore;
  logic [1:0][WORD_W-1:0]   w_iload;
  logic [1:0][WORD_W-1:0]   w_dload;

  logic [1:0] w_dact;
  logic       w_pref;
  logic       w_req;
  logic       w_c;
  logic       w_d;
  logic       w_sc_bad;
  logic       w_busy;
  logic       w_en;
  logic       w_acc;
  logic       w_ll;

  assign w_iaddr  = iaddr;
  assign w_daddr  = daddr;
  assign w_dstore = dstore;
  assign iload    = w_iload;
  assign dload    = w_dload;

  assign w_dact = dREN | dWEN;
  assign w_pref = ~r_last;

  // Data before instruction, preferred core before the other.
  always_comb begin
    w_req = 1'b1;
    w_c   = w_pref;
    w_d   = 1'b1;
    if (w_dact[w_pref]) begin
      w_c = w_pref;
      w_d = 1'b1;
    end else if (w_dact[~w_pref]) begin
      w_c = ~w_pref;
      w_d = 1'b1;
    end else if (iREN[w_pref]) begin
      w_c = w_pref;
      w_d = 1'b0;
    end else if (iREN[~w_pref]) begin
      w_c = ~w_pref;
      w_d = 1'b0;
    end else begin
      w_req = 1'b0;
    end
  end

  // An SC without a matching live reservation never touches RAM.
  assign w_sc_bad = w_d & dWEN[w_c] & datomic[w_c]
                  & (~r_link_v[w_c]
                     | (r_link_a[w_c] != w_daddr[w_c]));

  assign w_busy = (r_state == BUSY);
  assign w_en   = r_gnt_d ? w_dact[r_gnt_c] : iREN[r_gnt_c];
  assign w_acc  = w_busy & w_en & (ramstate == RS_ACCESS);
  assign w_ll   = r_gnt_d & dREN[r_gnt_c] & datomic[r_gnt_c];

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    if (w_busy) begin
      if (r_gnt_d) begin
        ramREN   = dREN[r_gnt_c];
        ramWEN   = dWEN[r_gnt_c];
        ramaddr  = w_daddr[r_gnt_c];
        ramstore = w_dstore[r_gnt_c];
      end else begin
        ramREN   = iREN[r_gnt_c];
        ramaddr  = w_iaddr[r_gnt_c];
      end
    end
  end

  always_comb begin
    ihit    = 2'b00;
    dhit    = 2'b00;
    w_iload = '0;
    w_dload = '0;
    if (w_acc && !r_gnt_d) begin
      ihit[r_gnt_c]    = 1'b1;
      w_iload[r_gnt_c] = ramload;
    end
    if (w_acc && r_gnt_d) begin
      dhit[r_gnt_c] = 1'b1;
      if (dWEN[r_gnt_c])
        w_dload[r_gnt_c] = {{(WORD_W-1){1'b0}},
                            datomic[r_gnt_c]};
      else
        w_dload[r_gnt_c] = ramload;
    end
    if (r_state == SCFAIL)
      dhit[r_gnt_c] = 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= IDLE;
      r_last   <= RR_INIT;
      r_gnt_c  <= 1'b0;
      r_gnt_d  <= 1'b0;
      r_link_v <= 2'b00;
      r_link_a <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_req) begin
            r_gnt_c <= w_c;
            r_gnt_d <= w_d;
            r_state <= w_sc_bad ? SCFAIL : BUSY;
          end
        end
        BUSY: begin
          if (!w_en) begin
            r_state <= IDLE;
          end else if (ramstate == RS_ACCESS) begin
            r_last  <= r_gnt_c;
            r_state <= GAP;
            // A completed write kills every reservation on its address.
            for (int k = 0; k < 2; k++) begin
              if (ramWEN && (r_link_a[k] == ramaddr))
                r_link_v[k] <= 1'b0;
            end
            if (w_ll) begin
              r_link_v[r_gnt_c] <= 1'b1;
              r_link_a[r_gnt_c] <= ramaddr;
            end
          end
        end
        SCFAIL: begin
          r_link_v[r_gnt_c] <= 1'b0;
          r_last            <= r_gnt_c;
          r_state           <= GAP;
        end
        GAP: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of arbitration order, RAM sequencing,
// LL/SC reservations, request abort and asynchronous reset.
module tb_mem_arbiter;

  logic              CLK = 1'b0;
  logic              nRST;
  logic [1:0]        iREN;
  logic [1:0][31:0]  ia;
  logic [1:0]        ihit;
  logic [63:0]       iload;
  logic [1:0]        dREN;
  logic [1:0]        dWEN;
  logic [1:0]        datomic;
  logic [1:0][31:0]  da;
  logic [1:0][31:0]  ds;
  logic [1:0]        dhit;
  logic [63:0]       dload;
  logic              ramREN;
  logic              ramWEN;
  logic [31:0]       ramaddr;
  logic [31:0]       ramstore;
  logic [31:0]       ramload;
  logic [1:0]        ramstate;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [1:0] RBUSY = 2'd1;
  localparam logic [1:0] RACC  = 2'd2;

  mem_arbiter #(.WORD_W(32), .RR_INIT(1'b0)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (ia),
    .ihit     (ihit),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .datomic  (datomic),
    .daddr    (da),
    .dstore   (ds),
    .dhit     (dhit),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the falling edge; checks follow #1 later.
  task automatic nxt();
    @(negedge CLK);
  endtask

  initial begin
    nRST = 1'b0; iREN = '0; ia = '0; dREN = '0; dWEN = '0;
    datomic = '0; da = '0; ds = '0; ramload = '0; ramstate = '0;
    nxt(); nxt(); #1;
    chk("rst_ramREN", ramREN, 0);
    chk("rst_ramWEN", ramWEN, 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_hits", {ihit, dhit}, 0);
    chk("rst_loads", {iload, dload}, 0);

    // Instruction fetch with two BUSY cycles before ACCESS
    nxt(); nRST = 1'b1;
    iREN = 2'b01; ia[0] = 32'h40; ramstate = RBUSY;
    ramload = 32'hDEADBEEF; #1;
    chk("t1_idle_ren", ramREN, 0);
    nxt(); #1;
    chk("t1_c1_ren", ramREN, 1);
    chk("t1_c1_addr", ramaddr, 32'h40);
    chk("t1_c1_hit", ihit, 0);
    nxt(); #1;
    chk("t1_c2_ren", ramREN, 1);
    chk("t1_c2_hit", ihit, 0);
    nxt(); ramstate = RACC; #1;
    chk("t1_c3_ren", ramREN, 1);
    chk("t1_c3_hit", ihit, 2'b01);
    chk("t1_c3_load", iload, 64'h0000_0000_DEAD_BEEF);
    nxt(); iREN = 2'b00; #1;
    chk("t1_gap_ren", ramREN, 0);
    chk("t1_gap_hit", ihit, 0);
    chk("t1_gap_load", iload, 0);
    nxt(); #1;
    chk("t1_idle2_ren", ramREN, 0);

    // Three simultaneous requesters, RAM always ACCESS
    iREN = 2'b11; dREN = 2'b01;
    ia[0] = 32'h40; ia[1] = 32'h44; da[0] = 32'h80;
    ramload = 32'h1111_1111;
    nxt(); #1;
    chk("t2_g1_dhit", dhit, 2'b01);
    chk("t2_g1_ihit", ihit, 0);
    chk("t2_g1_addr", ramaddr, 32'h80);
    chk("t2_g1_load", dload, 64'h0000_0000_1111_1111);
    nxt(); dREN = 2'b00; #1;
    chk("t2_gap1", {ihit, dhit}, 0);
    nxt(); #1;
    chk("t2_idle1", {ihit, dhit}, 0);
    nxt(); #1;
    chk("t2_g2_ihit", ihit, 2'b10);
    chk("t2_g2_addr", ramaddr, 32'h44);
    chk("t2_g2_load", iload, 64'h1111_1111_0000_0000);
    nxt(); iREN = 2'b01; #1;
    chk("t2_gap2", {ihit, dhit}, 0);
    nxt(); #1;
    chk("t2_idle2", {ihit, dhit}, 0);
    nxt(); #1;
    chk("t2_g3_ihit", ihit, 2'b01);
    chk("t2_g3_addr", ramaddr, 32'h40);
    nxt(); iREN = 2'b00; #1;
    chk("t2_gap3", {ihit, dhit}, 0);

    // Fresh reset, both dcaches held: core1, core0, core1
    nxt(); nRST = 1'b0;
    nxt(); nRST = 1'b1;
    dREN = 2'b11; da[0] = 32'h300; da[1] = 32'h304;
    ramload = 32'h22;
    nxt(); #1;
    chk("t3_g1_dhit", dhit, 2'b10);
    chk("t3_g1_addr", ramaddr, 32'h304);
    nxt(); nxt(); nxt(); #1;
    chk("t3_g2_dhit", dhit, 2'b01);
    chk("t3_g2_addr", ramaddr, 32'h300);
    nxt(); nxt(); nxt(); #1;
    chk("t3_g3_dhit", dhit, 2'b10);
    nxt(); dREN = 2'b00; #1;
    chk("t3_gap", dhit, 0);

    // LL by core0, store by core1 to same address, SC by core0 fails
    nxt();
    dREN = 2'b01; datomic = 2'b01; da[0] = 32'h100;
    nxt(); #1;
    chk("t4_ll_dhit", dhit, 2'b01);
    nxt(); dREN = 2'b00; datomic = 2'b00;
    nxt();
    dWEN = 2'b10; da[1] = 32'h100; ds[1] = 32'h55;
    nxt(); #1;
    chk("t4_sw_wen", ramWEN, 1);
    chk("t4_sw_store", ramstore, 32'h55);
    chk("t4_sw_dhit", dhit, 2'b10);
    nxt(); dWEN = 2'b00;
    nxt();
    dWEN = 2'b01; datomic = 2'b01; ds[0] = 32'h99;
    nxt(); #1;
    chk("t4_sc_dhit", dhit, 2'b01);
    chk("t4_sc_dload", dload, 0);
    chk("t4_sc_wen", ramWEN, 0);
    nxt(); dWEN = 2'b00; datomic = 2'b00; #1;
    chk("t4_gap", dhit, 0);

    // LL/SC success, then a second SC fails
    nxt();
    dREN = 2'b01; datomic = 2'b01; da[0] = 32'h200;
    ramload = 32'hAB;
    nxt(); #1;
    chk("t5_ll_dhit", dhit, 2'b01);
    chk("t5_ll_load", dload, 64'hAB);
    nxt(); dREN = 2'b00; datomic = 2'b00;
    nxt();
    dWEN = 2'b01; datomic = 2'b01; ds[0] = 32'h7;
    nxt(); #1;
    chk("t5_sc1_wen", ramWEN, 1);
    chk("t5_sc1_store", ramstore, 32'h7);
    chk("t5_sc1_addr", ramaddr, 32'h200);
    chk("t5_sc1_dhit", dhit, 2'b01);
    chk("t5_sc1_dload", dload, 64'h1);
    nxt(); dWEN = 2'b00; datomic = 2'b00;
    nxt();
    dWEN = 2'b01; datomic = 2'b01;
    nxt(); #1;
    chk("t5_sc2_dhit", dhit, 2'b01);
    chk("t5_sc2_dload", dload, 0);
    chk("t5_sc2_wen", ramWEN, 0);
    nxt(); dWEN = 2'b00; datomic = 2'b00;

    // dcache0 drops its request while RAM is BUSY
    nxt();
    dREN = 2'b01; da[0] = 32'h500;
    iREN = 2'b10; ia[1] = 32'h600;
    ramstate = RBUSY; ramload = 32'h66;
    nxt(); #1;
    chk("t6_busy_ren", ramREN, 1);
    chk("t6_busy_addr", ramaddr, 32'h500);
    chk("t6_busy_hit", {ihit, dhit}, 0);
    nxt(); dREN = 2'b00; #1;
    chk("t6_drop_ren", ramREN, 0);
    chk("t6_drop_hit", {ihit, dhit}, 0);
    nxt(); ramstate = RACC; #1;
    chk("t6_idle_ren", ramREN, 0);
    chk("t6_idle_hit", {ihit, dhit}, 0);
    nxt(); #1;
    chk("t6_i1_ihit", ihit, 2'b10);
    chk("t6_i1_addr", ramaddr, 32'h600);
    nxt(); iREN = 2'b00;

    // Reset mid-transaction
    nxt();
    iREN = 2'b01; ia[0] = 32'h40; ramstate = RBUSY;
    nxt(); #1;
    chk("t7_busy_ren", ramREN, 1);
    nRST = 1'b0; #1;
    chk("t7_rst_ren", ramREN, 0);
    ramstate = RACC; #1;
    chk("t7_rst_hit", {ihit, dhit}, 0);
    chk("t7_rst_addr", ramaddr, 0);
    nxt(); nRST = 1'b1; iREN = 2'b00; #1;
    chk("t7_post_ren", ramREN, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single RAM port between the four cache-side requesters of the dual-core CPU: icache0, dcache0, icache1 and dcache1.
- Sequences one RAM transaction at a time and returns a one-cycle hit pulse to the winning requester.
- Tracks one load-link reservation per core, so datomic stores (SC) succeed or fail correctly.
- Sits between the per-core datapath/cache pairs and the RAM model.

Parameters:
- WORD_W, 32, data/address width
- RR_INIT, 0, core index treated as "last granted" after reset (core 1 therefore wins the first tie)

Ports:
- CLK  input  1  clock
- nRST  input  1  reset, asynchronous, active-low
- iREN  input  2  instruction read request, bit n = core n
- iaddr  input  2*WORD_W  instruction address, core n at [32n+31:32n]
- ihit  output  2  one-cycle instruction completion pulse
- iload  output  2*WORD_W  instruction data, valid only while ihit[n]
- dREN  input  2  data read request
- dWEN  input  2  data write request (dREN and dWEN never both set for one core)
- datomic  input  2  qualifies dREN as LL, dWEN as SC
- daddr  input  2*WORD_W  data address
- dstore  input  2*WORD_W  write data
- dhit  output  2  one-cycle data completion pulse
- dload  output  2*WORD_W  read data, or SC result, valid only while dhit[n]
- ramREN  output  1  RAM read enable
- ramWEN  output  1  RAM write enable
- ramaddr  output  WORD_W  RAM address
- ramstore  output  WORD_W  RAM write data
- ramload  input  WORD_W  RAM read data
- ramstate  input  2  0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR

Behaviour:
- Reset values:
  - state = IDLE, last = RR_INIT.
  - link_valid = 00, link_addr = 0.
  - All hit outputs 0; all load outputs 0.
  - ramREN/ramWEN 0; ramaddr/ramstore 0.
- IDLE, winner selection: pref = !last. Candidate order is dcache[pref], dcache[!pref], icache[pref], icache[!pref]. The first active candidate is latched as the grant (requester id and kind) and the state moves to BUSY. No active requester: stay in IDLE.
- SC check in IDLE: if the winner is dWEN & datomic and (!link_valid[c] | link_addr[c] != daddr[c]):
  - go to SCFAIL; no RAM access.
- BUSY:
  - ramREN/ramWEN/ramaddr/ramstore are driven combinationally from the granted requester's live inputs.
  - ramstate==ACCESS in a cycle: assert the granted hit that same cycle. Reads route ramload to the load output. A successful SC sets dload = 1.
  - Then last <= granted core and the state moves to GAP.
  - ramstate ERROR or BUSY: keep waiting; no timeout.
- Request dropped while BUSY (granted enable low): abort to IDLE. No hit, no link change, last unchanged.
- SCFAIL: assert dhit[c] with dload = 0 for exactly one cycle; last <= c; go to GAP.
- GAP: one dead cycle with no RAM enables and no hits, so requesters can deassert. Then go to IDLE.
- Arbitration latency: a request seen in IDLE at cycle t drives RAM at t+1. Minimum hit is at t+1 when ACCESS is returned immediately. Back-to-back grants are at least 3 cycles apart.
- Link rules, applied on the ACCESS cycle of the granted transaction:
  - LL (dREN & datomic) from core c: link_valid[c] <= 1, link_addr[c] <= addr.
  - Any completed write (plain or SC, either core) to address A clears every link_valid[k] with link_addr[k]==A. This includes the writer's own link, so a successful SC consumes its link.
  - A failed SC clears the requester's own link.
  - Address compare is full WORD_W width.
- Only one transaction is outstanding at a time. At most one bit across ihit|dhit is set in any cycle.
- Reset asserted mid-transaction: everything returns to reset values immediately and no hit is emitted.

Test Plan:
- Reset, then iREN=01, iaddr0=0x40, RAM returns ACCESS after 2 BUSY cycles with ramload=0xDEADBEEF -> ramREN=1, ramaddr=0x40 for 3 cycles; ihit=01 with iload0=0xDEADBEEF on the 3rd; GAP, then IDLE.
- iREN=11 and dREN=01 simultaneously, RAM always ACCESS -> grant order dcache0, icache1, icache0. hit pulses are 3 cycles apart.
- Both dREN=11 held continuously, with RR_INIT=0 -> grants alternate core1, core0, core1.
- Core0 LL 0x100, core1 SW 0x100, core0 SC 0x100 -> SC gets dhit0 with dload0=0 and no ramWEN.
- Core0 LL 0x200, then SC 0x200 with dstore=7 -> ramWEN with 7; dload0=1. A second SC to 0x200 fails with dload0=0.
- dREN0 dropped while BUSY (ramstate=BUSY) -> no dhit; next IDLE cycle serves the pending icache1 request.
